// File: rtl/cpu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pipe_pkg
// Brief    : Shared decode/execute control types, opcodes and field masks.
// Revision : 1.0
// ============================================================================
package cpu_pipe_pkg;

    localparam int unsigned OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_SUB    = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_ADD    = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_AND    = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_OR     = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_BEQ    = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_BNE    = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_BLT    = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_BGT    = 4'b0111;
    localparam logic [OPCODE_W-1:0] OP_MOVI   = 4'b1000;
    localparam logic [OPCODE_W-1:0] OP_LDR    = 4'b1001;
    localparam logic [OPCODE_W-1:0] OP_STR    = 4'b1010;
    localparam logic [OPCODE_W-1:0] OP_CMP    = 4'b1011;
    localparam logic [OPCODE_W-1:0] OP_MOVR   = 4'b1100;
    localparam logic [OPCODE_W-1:0] OP_BUBBLE = 4'b1111;

    typedef struct packed {
        logic       select_next_pc;
        logic       wbs;
        logic       mm;
        logic [2:0] alu_op;
        logic [1:0] ri;
        logic       wre;
        logic       wm;
        logic       am;
        logic       ni;
        logic       wme;
        logic       alu_mux;
        logic       alu_mux1;
        logic       rde;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // A 1 marks a field the given opcode actually defines; everything else is don't-care.
    function automatic ctrl_t ctrl_mask(input logic [OPCODE_W-1:0] opcode);
        ctrl_t m;
        m = '1;
        case (opcode)
            OP_SUB, OP_ADD, OP_AND, OP_OR, OP_CMP, OP_MOVR: begin
                m.am  = 1'b0;
                m.wme = 1'b0;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGT: begin
                m.wbs    = 1'b0;
                m.alu_op = '0;
                m.wm     = 1'b0;
                m.am     = 1'b0;
                m.wme    = 1'b0;
                if (opcode == OP_BLT) begin
                    m.alu_mux1 = 1'b0;
                end
            end
            OP_MOVI: begin
                m.alu_op = '0;
                m.wme    = 1'b0;
            end
            OP_LDR: begin
                m.wme = 1'b0;
            end
            OP_STR: begin
                m.wbs = 1'b0;
                m.wm  = 1'b0;
            end
            default: begin
                m = '0;
            end
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_reg_ctrl_sanitize.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_sanitize
// Brief    : Forces decoder don't-care control fields to zero; flags illegal opcodes.
// Revision : 1.0
// ============================================================================
module ctrl_sanitize
    import cpu_pipe_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  ctrl_t               in_ctrl,
    output ctrl_t               out_ctrl,
    output logic                illegal
);

    ctrl_t w_mask;

    assign w_mask   = ctrl_mask(opcode);
    assign out_ctrl = ctrl_t'(in_ctrl & w_mask);
    assign illegal  = (opcode > OP_MOVR);

endmodule
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_reg
// Brief    : ID/EX pipeline register with stall, flush and control sanitization.
// Revision : 1.0
// ============================================================================
module id_ex_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int REG_AW = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [OPCODE_W-1:0] in_opcode,
    input  ctrl_t               in_ctrl,
    input  logic [PC_W-1:0]     in_pc,
    input  logic [DATA_W-1:0]   in_rd1,
    input  logic [DATA_W-1:0]   in_rd2,
    input  logic [DATA_W-1:0]   in_imm,
    input  logic [REG_AW-1:0]   in_rs1,
    input  logic [REG_AW-1:0]   in_rs2,
    input  logic [REG_AW-1:0]   in_rd,
    output logic                ex_valid,
    output logic [OPCODE_W-1:0] ex_opcode,
    output ctrl_t               ex_ctrl,
    output logic [PC_W-1:0]     ex_pc,
    output logic [DATA_W-1:0]   ex_rd1,
    output logic [DATA_W-1:0]   ex_rd2,
    output logic [DATA_W-1:0]   ex_imm,
    output logic [REG_AW-1:0]   ex_rs1,
    output logic [REG_AW-1:0]   ex_rs2,
    output logic [REG_AW-1:0]   ex_rd,
    output logic                illegal_op
);

    ctrl_t w_clean_ctrl;
    logic  w_illegal;
    logic  w_take;

    logic                r_valid;
    logic [OPCODE_W-1:0] r_opcode;
    ctrl_t               r_ctrl;
    logic [PC_W-1:0]     r_pc;
    logic [DATA_W-1:0]   r_rd1;
    logic [DATA_W-1:0]   r_rd2;
    logic [DATA_W-1:0]   r_imm;
    logic [REG_AW-1:0]   r_rs1;
    logic [REG_AW-1:0]   r_rs2;
    logic [REG_AW-1:0]   r_rd;
    logic                r_illegal;

    ctrl_sanitize u_ctrl_sanitize (
        .opcode   (in_opcode),
        .in_ctrl  (in_ctrl),
        .out_ctrl (w_clean_ctrl),
        .illegal  (w_illegal)
    );

    // Only a valid, legal instruction is captured; anything else becomes a bubble.
    assign w_take = in_valid && !w_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_opcode  <= '0;
            r_ctrl    <= CTRL_BUBBLE;
            r_pc      <= '0;
            r_rd1     <= '0;
            r_rd2     <= '0;
            r_imm     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_illegal <= 1'b0;
        end else if (flush || (!stall && !w_take)) begin
            r_valid   <= 1'b0;
            r_opcode  <= OP_BUBBLE;
            r_ctrl    <= CTRL_BUBBLE;
            r_pc      <= '0;
            r_rd1     <= '0;
            r_rd2     <= '0;
            r_imm     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            if (!flush && in_valid && w_illegal) begin
                r_illegal <= 1'b1;
            end
        end else if (!stall) begin
            r_valid   <= 1'b1;
            r_opcode  <= in_opcode;
            r_ctrl    <= w_clean_ctrl;
            r_pc      <= in_pc;
            r_rd1     <= in_rd1;
            r_rd2     <= in_rd2;
            r_imm     <= in_imm;
            r_rs1     <= in_rs1;
            r_rs2     <= in_rs2;
            r_rd      <= in_rd;
        end
    end

    assign ex_valid   = r_valid;
    assign ex_opcode  = r_opcode;
    assign ex_ctrl    = r_ctrl;
    assign ex_pc      = r_pc;
    assign ex_rd1     = r_rd1;
    assign ex_rd2     = r_rd2;
    assign ex_imm     = r_imm;
    assign ex_rs1     = r_rs1;
    assign ex_rs2     = r_rs2;
    assign ex_rd      = r_rd;
    assign illegal_op = r_illegal;

endmodule
`default_nettype wire
